// File: rtl/async_fifo_wr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : async_fifo_wr_ctrl_if
// Description : Write-side bundle of the asynchronous FIFO. It carries the
//               push request, the overflow clear, the read-domain Gray pointer,
//               the RAM write port and the write-side status flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface async_fifo_wr_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);

  logic                  wr_req;
  logic                  ovf_clr;
  logic [ADDR_WIDTH:0]   rd_ptr_gray;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [ADDR_WIDTH:0]   wr_ptr_gray;
  logic                  wr_full;
  logic                  wr_almost_full;
  logic [ADDR_WIDTH:0]   wr_level;
  logic                  wr_overflow;
  logic                  wr_ovf_sticky;

  // Producer / read-domain side: drives requests and the remote pointer
  modport master (
    output wr_req, ovf_clr, rd_ptr_gray,
    input  ram_wr_en, ram_wr_addr, wr_ptr_gray, wr_full, wr_almost_full,
           wr_level, wr_overflow, wr_ovf_sticky
  );

  // Write controller side
  modport slave (
    input  wr_req, ovf_clr, rd_ptr_gray,
    output ram_wr_en, ram_wr_addr, wr_ptr_gray, wr_full, wr_almost_full,
           wr_level, wr_overflow, wr_ovf_sticky
  );

endinterface
`default_nettype wire

// File: rtl/async_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : async_fifo_wr_ctrl
// Description : Write-domain controller of the asynchronous FIFO. Accepts
//               pushes, drives the RAM write port, keeps binary and Gray
//               write pointers, synchronises the read Gray pointer and derives
//               full / almost-full / level / overflow status.
// Revision    : 1.0 - initial release
// ============================================================================
module async_fifo_wr_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 2,
  parameter int SYNC_STAGES  = 2
) (
  input  wire logic           wr_clk,
  input  wire logic           wr_rst_n,
  async_fifo_wr_ctrl_if.slave wr_bus
);

  localparam logic [ADDR_WIDTH:0] c_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] c_AFULL = (ADDR_WIDTH+1)'(AFULL_THRESH);

  // Plain reflected-binary encoding
  function automatic logic [ADDR_WIDTH:0] f_bin2gray(input logic [ADDR_WIDTH:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it
  function automatic logic [ADDR_WIDTH:0] f_gray2bin(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  logic [ADDR_WIDTH:0]                   r_wbin;
  logic [ADDR_WIDTH:0]                   r_wgray;
  logic [SYNC_STAGES-1:0][ADDR_WIDTH:0]  r_sync;
  logic                                  r_ovf;
  logic                                  r_ovf_sticky;

  logic [ADDR_WIDTH:0] w_rq;
  logic [ADDR_WIDTH:0] w_rbin;
  logic [ADDR_WIDTH:0] w_wbin_nxt;
  logic [ADDR_WIDTH:0] w_level;
  logic                w_full;
  logic                w_push;
  logic                w_reject;

  assign w_rq       = r_sync[SYNC_STAGES-1];
  assign w_rbin     = f_gray2bin(w_rq);
  assign w_wbin_nxt = r_wbin + c_ONE;

  // Full when the write pointer is exactly one lap ahead of the synced read
  // pointer; in Gray form that means the top two bits inverted.
  assign w_full   = (r_wgray == {~w_rq[ADDR_WIDTH:ADDR_WIDTH-1], w_rq[ADDR_WIDTH-2:0]});
  assign w_level  = r_wbin - w_rbin;

  // Reset gates the accept path so a request held through reset never writes
  assign w_push   = wr_rst_n & wr_bus.wr_req & ~w_full;
  assign w_reject = wr_bus.wr_req & w_full;

  // Read pointer crosses into wr_clk only through this shift chain
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], wr_bus.rd_ptr_gray};
    end
  end

  // Write pointer advances on each accepted push, Gray copy kept registered
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_wbin  <= '0;
      r_wgray <= '0;
    end else if (w_push) begin
      r_wbin  <= w_wbin_nxt;
      r_wgray <= f_bin2gray(w_wbin_nxt);
    end
  end

  // One-cycle overflow pulse and sticky flag; a new rejection beats a clear
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_ovf        <= 1'b0;
      r_ovf_sticky <= 1'b0;
    end else begin
      r_ovf <= w_reject;
      if (w_reject) begin
        r_ovf_sticky <= 1'b1;
      end else if (wr_bus.ovf_clr) begin
        r_ovf_sticky <= 1'b0;
      end
    end
  end

  assign wr_bus.ram_wr_en      = w_push;
  assign wr_bus.ram_wr_addr    = r_wbin[ADDR_WIDTH-1:0];
  assign wr_bus.wr_ptr_gray    = r_wgray;
  assign wr_bus.wr_full        = w_full;
  assign wr_bus.wr_level       = w_level;
  assign wr_bus.wr_almost_full = (w_level >= c_AFULL);
  assign wr_bus.wr_overflow    = r_ovf;
  assign wr_bus.wr_ovf_sticky  = r_ovf_sticky;

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_async_fifo_wr_ctrl
// Description : Self-checking bench for async_fifo_wr_ctrl with a write
//               address scoreboard and an asynchronous read-side model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_async_fifo_wr_ctrl;

  logic wr_clk;
  logic rd_clk;
  logic wr_rst_n;

  async_fifo_wr_ctrl_if #(.ADDR_WIDTH(4)) bus ();

  async_fifo_wr_ctrl #(
    .ADDR_WIDTH   (4),
    .AFULL_THRESH (14),
    .SYNC_STAGES  (2)
  ) dut (
    .wr_clk   (wr_clk),
    .wr_rst_n (wr_rst_n),
    .wr_bus   (bus.slave)
  );

  int         n_total = 0;
  int         n_bad   = 0;
  int         wr_count = 0;
  int         rd_count = 0;
  logic       rd_run = 1'b0;
  logic [3:0] exp_q[$];
  logic [4:0] prev_gray;

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  initial begin
    rd_clk = 1'b0;
    forever #7 rd_clk = ~rd_clk;
  end

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_rst(input string tag);
    chk({tag, "_en"},     {31'b0, bus.ram_wr_en},      0);
    chk({tag, "_addr"},   {28'b0, bus.ram_wr_addr},    0);
    chk({tag, "_gray"},   {27'b0, bus.wr_ptr_gray},    0);
    chk({tag, "_full"},   {31'b0, bus.wr_full},        0);
    chk({tag, "_afull"},  {31'b0, bus.wr_almost_full}, 0);
    chk({tag, "_level"},  {27'b0, bus.wr_level},       0);
    chk({tag, "_ovf"},    {31'b0, bus.wr_overflow},    0);
    chk({tag, "_sticky"}, {31'b0, bus.wr_ovf_sticky},  0);
  endtask

  // Called just after a falling edge; returns just after the next one
  task automatic drive_cycle(input logic req, input logic clr, input int exp_en);
    bus.wr_req  = req;
    bus.ovf_clr = clr;
    #2;
    if (exp_en >= 0) chk("wr_en", {31'b0, bus.ram_wr_en}, exp_en[31:0]);
    if (bus.ram_wr_en) begin
      chk("no_overwrite", {31'b0, ((wr_count - rd_count) < 16)}, 1);
      chk("sb_nonempty", {31'b0, (exp_q.size() > 0)}, 1);
      if (exp_q.size() > 0) chk("wr_addr", {28'b0, bus.ram_wr_addr}, {28'b0, exp_q.pop_front()});
      wr_count++;
    end
    @(posedge wr_clk);
    @(negedge wr_clk);
  endtask

  task automatic do_reset();
    bus.wr_req      = 1'b0;
    bus.ovf_clr     = 1'b0;
    bus.rd_ptr_gray = '0;
    wr_rst_n        = 1'b0;
    #2;
    wr_rst_n = 1'b1;
    wr_count = 0;
    rd_count = 0;
    exp_q.delete();
    @(negedge wr_clk);
  endtask

  // Read-side model: consumes written entries at an unrelated rate
  initial begin
    forever begin
      @(posedge rd_clk);
      if (rd_run && (rd_count < wr_count) && ($urandom_range(0, 2) != 0)) begin
        rd_count++;
        bus.rd_ptr_gray = gray5(rd_count);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset with a pending request ----------------
    wr_rst_n        = 1'b0;
    bus.wr_req      = 1'b1;
    bus.ovf_clr     = 1'b0;
    bus.rd_ptr_gray = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge wr_clk);
      check_rst("rst");
    end
    bus.wr_req = 1'b0;
    wr_rst_n   = 1'b1;
    @(negedge wr_clk);

    // ---------------- fill 16 back-to-back ----------------
    for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b1, 1'b0, 1);
      chk("fill_level", {27'b0, bus.wr_level},       i + 1);
      chk("fill_afull", {31'b0, bus.wr_almost_full}, {31'b0, (i + 1 >= 14)});
      chk("fill_full",  {31'b0, bus.wr_full},        {31'b0, (i + 1 == 16)});
      chk("fill_gray",  {27'b0, bus.wr_ptr_gray},    {27'b0, gray5(i + 1)});
    end
    chk("fill_sb_empty", exp_q.size(), 0);

    // ---------------- overflow while full ----------------
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0, 0);
      chk("ovf_pulse",  {31'b0, bus.wr_overflow},   1);
      chk("ovf_sticky", {31'b0, bus.wr_ovf_sticky}, 1);
      chk("ovf_gray",   {27'b0, bus.wr_ptr_gray},   {27'b0, gray5(16)});
      chk("ovf_addr",   {28'b0, bus.ram_wr_addr},   0);
    end
    drive_cycle(1'b0, 1'b0, 0);
    chk("ovf_idle_pulse",  {31'b0, bus.wr_overflow},   0);
    chk("ovf_idle_sticky", {31'b0, bus.wr_ovf_sticky}, 1);
    drive_cycle(1'b1, 1'b1, 0);
    chk("ovf_setwins_pulse",  {31'b0, bus.wr_overflow},   1);
    chk("ovf_setwins_sticky", {31'b0, bus.wr_ovf_sticky}, 1);
    drive_cycle(1'b0, 1'b1, 0);
    chk("ovf_clr_pulse",  {31'b0, bus.wr_overflow},   0);
    chk("ovf_clr_sticky", {31'b0, bus.wr_ovf_sticky}, 0);

    // ---------------- drain visibility ----------------
    bus.rd_ptr_gray = 5'b00110;
    rd_count        = 4;
    drive_cycle(1'b0, 1'b0, 0);
    chk("drain_e1_full", {31'b0, bus.wr_full}, 1);
    drive_cycle(1'b0, 1'b0, 0);
    chk("drain_full",  {31'b0, bus.wr_full},        0);
    chk("drain_level", {27'b0, bus.wr_level},       12);
    chk("drain_afull", {31'b0, bus.wr_almost_full}, 0);
    exp_q.push_back(4'd0);
    drive_cycle(1'b1, 1'b0, 1);
    chk("drain_push_level", {27'b0, bus.wr_level}, 13);

    // ---------------- reset mid-fill ----------------
    do_reset();
    for (int i = 0; i < 9; i++) exp_q.push_back(4'(i));
    for (int i = 0; i < 9; i++) drive_cycle(1'b1, 1'b0, 1);
    chk("mid_level_pre", {27'b0, bus.wr_level}, 9);
    bus.wr_req = 1'b1;
    #2;
    wr_rst_n = 1'b0;
    #1;
    check_rst("midrst");
    bus.wr_req = 1'b0;
    #1;
    wr_rst_n = 1'b1;
    wr_count = 0;
    rd_count = 0;
    @(negedge wr_clk);
    exp_q.push_back(4'd0);
    drive_cycle(1'b1, 1'b0, 1);
    chk("mid_post_level", {27'b0, bus.wr_level}, 1);

    // ---------------- wrap-around with async reader ----------------
    do_reset();
    for (int i = 0; i < 40; i++) exp_q.push_back(4'(i % 16));
    prev_gray = bus.wr_ptr_gray;
    rd_run    = 1'b1;
    for (int cyc = 0; cyc < 1000 && wr_count < 40; cyc++) begin
      drive_cycle(1'b1, 1'b0, -1);
      chk("wrap_gray_1bit", {31'b0, ($countones(prev_gray ^ bus.wr_ptr_gray) <= 1)}, 1);
      chk("wrap_level_max", {31'b0, (bus.wr_level <= 5'd16)}, 1);
      chk("wrap_level_pess", {31'b0, (int'(bus.wr_level) >= (wr_count - rd_count))}, 1);
      chk("wrap_full_vs_level", {31'b0, bus.wr_full}, {31'b0, (bus.wr_level == 5'd16)});
      chk("wrap_afull_vs_level", {31'b0, bus.wr_almost_full}, {31'b0, (bus.wr_level >= 5'd14)});
      prev_gray = bus.wr_ptr_gray;
    end
    bus.wr_req = 1'b0;
    rd_run     = 1'b0;
    chk("wrap_count", wr_count, 40);
    chk("wrap_sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/async_fifo_wr_ctrl.md
# async_fifo_wr_ctrl

Write-side controller of the asynchronous FIFO, sitting entirely in the wr_clk domain. It is the producer counterpart to the read-side logic of the dual-port async RAM. It accepts push requests, generates the RAM write enable and address, and keeps a binary plus Gray write pointer. It also synchronizes the read domain's Gray pointer into wr_clk and from it derives full, almost-full, fill level and overflow status.

## Interface
- ADDR_WIDTH, 4: RAM address width; DEPTH = 2^ADDR_WIDTH; must be >= 2.
- AFULL_THRESH, 2^ADDR_WIDTH-2: level at or above which wr_almost_full asserts; range 1..DEPTH.
- SYNC_STAGES, 2: flop stages on the rd_ptr_gray synchronizer; must be >= 2.

Ports (reset wr_rst_n, asynchronous, active-low; clock wr_clk):
- wr_clk  in  1  write-domain clock
- wr_rst_n  in  1  asynchronous active-low reset, wr_clk domain
- wr_req  in  1  push request; data travels directly from the user to the RAM wr_data
- ovf_clr  in  1  clears wr_ovf_sticky
- rd_ptr_gray  in  ADDR_WIDTH+1  read pointer, Gray, from the rd_clk domain (asynchronous)
- ram_wr_en  out  1  RAM write enable
- ram_wr_addr  out  ADDR_WIDTH  RAM write address
- wr_ptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, to the read-domain synchronizer
- wr_full  out  1  FIFO full, pessimistic
- wr_almost_full  out  1  wr_level >= AFULL_THRESH
- wr_level  out  ADDR_WIDTH+1  occupancy as seen by the write side, 0..DEPTH
- wr_overflow  out  1  one-cycle pulse for a rejected push
- wr_ovf_sticky  out  1  sticky overflow flag

## Operation
- State registers:
  - wbin: binary write pointer, ADDR_WIDTH+1 bits.
  - wgray: equals bin2gray(wbin), registered; drives wr_ptr_gray directly.
  - sync chain: SYNC_STAGES x (ADDR_WIDTH+1) flops; the last stage is rq.
  - Overflow pulse flop and sticky flop.
- Push accept: ram_wr_en = wr_req & ~wr_full, combinational from wr_req and registered state.
- ram_wr_addr = wbin[ADDR_WIDTH-1:0].
- On an accepted push: wbin <= wbin+1, and wgray <= bin2gray(wbin+1). Both wrap modulo 2^(ADDR_WIDTH+1).
- wr_full = (wgray == {~rq[A:A-1], rq[A-2:0]}), where A = ADDR_WIDTH. It is derived only from registers.
- wr_level = wbin - gray2bin(rq), modulo 2^(ADDR_WIDTH+1). It is never greater than DEPTH.
- wr_almost_full = (wr_level >= AFULL_THRESH).
- Rejected push (wr_req & wr_full):
  - No RAM write and no pointer change.
  - wr_overflow = 1 on the next cycle, for exactly one cycle.
  - wr_ovf_sticky is set.
- wr_ovf_sticky is cleared by ovf_clr. If set and clear fall in the same cycle, set wins.
- The flags are pessimistic. A read is seen late, so full/level lag reads. A write is never seen late, so the FIFO never overflows the RAM.
- The rd_ptr_gray input is consumed only through the synchronizer. No other logic may sample it.

## Timing
- Reset values:
  - wbin = 0, wgray = 0, all sync stages = 0.
  - ram_wr_en = 0 (wr_req ignored while in reset), ram_wr_addr = 0, wr_ptr_gray = 0.
  - wr_full = 0, wr_level = 0, wr_almost_full = 0.
  - wr_overflow = 0, wr_ovf_sticky = 0.
- Write latency: the RAM is written on the same wr_clk edge that accepts the push.
  - wr_level, wr_full, wr_almost_full and wr_ptr_gray reflect the push on the cycle after that edge.
- Read visibility: a change on rd_ptr_gray stable before edge k is visible in rq after edge k+SYNC_STAGES-1. With the default, that is the 2nd wr_clk edge after the change.
- Full and write in the same cycle: if wr_full is 1, the push is rejected even if a read is in flight.
- wr_ptr_gray changes at most one bit per wr_clk edge, including the wrap from 2^(A+1)-1 to 0.
- Reset mid-operation:
  - Everything returns to reset values immediately (asynchronous), and any in-flight push is dropped.
  - Both domains must be reset together. The block makes no recovery attempt for a one-sided reset.

## Test plan
- Reset: assert wr_rst_n=0 with wr_req=1 -> every output at its reset value; ram_wr_en=0 throughout reset.
- Fill (default params, rd_ptr_gray held at 0): push 16 times back-to-back.
  - ram_wr_addr runs 0..15.
  - wr_almost_full rises the cycle after the 14th push.
  - wr_full rises and wr_level=16 the cycle after the 16th push.
- Overflow: while full, drive wr_req=1 for 3 cycles.
  - ram_wr_en stays 0 and wbin is unchanged.
  - wr_overflow pulses once per rejected cycle; wr_ovf_sticky=1 until ovf_clr, with set beating clear when both occur in the same cycle.
- Drain visibility: from full, drive rd_ptr_gray = gray(4) = 5'b00110 -> after 2 wr_clk edges wr_full=0, wr_level=12, wr_almost_full=0. The next push writes address 0.
- Wrap-around: 40 pushes with a read model advancing rd_ptr_gray asynchronously (unrelated clock ratio).
  - ram_wr_addr wraps 15->0 twice, and wr_ptr_gray is checked for single-bit changes every edge.
  - A scoreboard confirms no write ever overwrites unread data, and wr_level <= 16 always.
- Reset mid-fill: after 9 pushes, pulse wr_rst_n low between edges -> all outputs return to their reset values immediately. The first push after release writes address 0.
